// File: rtl/axi_lite_pkg.sv
// rtl/axi_lite_pkg.sv - shared widths, response codes and FSM state types for the AXI-Lite SRAM slave
package axi_lite_pkg;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int STRB_W = 4;

    typedef enum logic [1:0] {
        RESP_OKAY   = 2'b00,
        RESP_SLVERR = 2'b10
    } resp_t;

    typedef enum logic {
        W_COLLECT,
        W_RESP
    } wstate_t;

    typedef enum logic [1:0] {
        R_IDLE,
        R_WAIT,
        R_RESP
    } rstate_t;

endpackage

// File: rtl/axi_sram_array.sv
// rtl/axi_sram_array.sv - DEPTH_WORDS x 32 storage: byte-enabled write port, registered read port
module axi_sram_array
    import axi_lite_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int IDX_W       = $clog2(DEPTH_WORDS)
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [IDX_W-1:0]  i_widx,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic [STRB_W-1:0] i_wstrb,
    input  logic              i_re,
    input  logic [IDX_W-1:0]  i_ridx,
    output logic [DATA_W-1:0] o_rdata
);

    logic [DATA_W-1:0] r_mem [DEPTH_WORDS];
    logic [DATA_W-1:0] r_rdata;

    // Contents are deliberately never reset; the read register holds until the next read.
    always_ff @(posedge clk) begin
        for (int b = 0; b < STRB_W; b++) begin
            if (i_we && i_wstrb[b]) begin
                r_mem[i_widx][b*8 +: 8] <= i_wdata[b*8 +: 8];
            end
        end
        if (i_re) begin
            r_rdata <= r_mem[i_ridx];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/axi_lite_sram_slave.sv
// rtl/axi_lite_sram_slave.sv - AXI4-Lite responder in front of a byte-enabled SRAM
module axi_lite_sram_slave
    import axi_lite_pkg::*;
#(
    parameter logic [ADDR_W-1:0] BASE_ADDR   = 32'h0000_0000,
    parameter int                DEPTH_WORDS = 1024,
    parameter int                RD_LATENCY  = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] awaddr,
    input  logic              awvalid,
    output logic              awready,
    input  logic [DATA_W-1:0] wdata,
    input  logic [STRB_W-1:0] wstrb,
    input  logic              wvalid,
    output logic              wready,
    output logic [1:0]        bresp,
    output logic              bvalid,
    input  logic              bready,
    input  logic [ADDR_W-1:0] araddr,
    input  logic              arvalid,
    output logic              arready,
    output logic [DATA_W-1:0] rdata,
    output logic [1:0]        rresp,
    output logic              rvalid,
    input  logic              rready
);

    localparam int            IDX_W    = $clog2(DEPTH_WORDS);
    localparam logic [ADDR_W:0] SPAN   = (ADDR_W+1)'(DEPTH_WORDS * 4);
    localparam logic [3:0]    LAT_LOAD = 4'(RD_LATENCY - 1);

    function automatic logic f_in_range(input logic [ADDR_W-1:0] a);
        return (a >= BASE_ADDR) && ({1'b0, a - BASE_ADDR} < SPAN);
    endfunction

    function automatic logic [IDX_W-1:0] f_index(input logic [ADDR_W-1:0] a);
        return IDX_W'((a - BASE_ADDR) >> 2);
    endfunction

    wstate_t           r_wstate, w_wstate_nxt;
    logic              r_aw_full, w_aw_full_nxt;
    logic              r_w_full, w_w_full_nxt;
    logic [ADDR_W-1:0] r_awaddr, w_awaddr_nxt;
    logic [DATA_W-1:0] r_wdata, w_wdata_nxt;
    logic [STRB_W-1:0] r_wstrb, w_wstrb_nxt;
    resp_t             r_bresp, w_bresp_nxt;
    logic              r_awready, r_wready;
    logic              w_awready_nxt, w_wready_nxt;
    logic              w_wr_ok, w_mem_we;

    rstate_t           r_rstate, w_rstate_nxt;
    logic [3:0]        r_rcnt, w_rcnt_nxt;
    logic              r_rd_err, w_rd_err_nxt;
    logic              r_arready, w_arready_nxt;
    logic              w_ar_ok, w_mem_re;
    logic [DATA_W-1:0] w_mem_rdata;

    assign w_wr_ok = f_in_range(r_awaddr);
    assign w_ar_ok = f_in_range(araddr);

    always_comb begin
        w_wstate_nxt  = r_wstate;
        w_aw_full_nxt = r_aw_full;
        w_w_full_nxt  = r_w_full;
        w_awaddr_nxt  = r_awaddr;
        w_wdata_nxt   = r_wdata;
        w_wstrb_nxt   = r_wstrb;
        w_bresp_nxt   = r_bresp;
        w_mem_we      = 1'b0;
        case (r_wstate)
            W_COLLECT: begin
                if (r_aw_full && r_w_full) begin
                    // Out-of-range writes are dropped but still answered.
                    w_mem_we     = w_wr_ok;
                    w_wstate_nxt = W_RESP;
                    if (w_wr_ok) begin
                        w_bresp_nxt = RESP_OKAY;
                    end else begin
                        w_bresp_nxt = RESP_SLVERR;
                    end
                end else begin
                    if (awvalid && r_awready) begin
                        w_aw_full_nxt = 1'b1;
                        w_awaddr_nxt  = awaddr;
                    end
                    if (wvalid && r_wready) begin
                        w_w_full_nxt = 1'b1;
                        w_wdata_nxt  = wdata;
                        w_wstrb_nxt  = wstrb;
                    end
                end
            end
            W_RESP: begin
                if (bready) begin
                    w_wstate_nxt  = W_COLLECT;
                    w_aw_full_nxt = 1'b0;
                    w_w_full_nxt  = 1'b0;
                end
            end
            default: w_wstate_nxt = W_COLLECT;
        endcase
    end

    // Readies are registered from next state so they never follow a valid combinationally.
    assign w_awready_nxt = (w_wstate_nxt == W_COLLECT) && !w_aw_full_nxt;
    assign w_wready_nxt  = (w_wstate_nxt == W_COLLECT) && !w_w_full_nxt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wstate  <= W_COLLECT;
            r_aw_full <= 1'b0;
            r_w_full  <= 1'b0;
            r_awaddr  <= '0;
            r_wdata   <= '0;
            r_wstrb   <= '0;
            r_bresp   <= RESP_OKAY;
            r_awready <= 1'b0;
            r_wready  <= 1'b0;
        end else begin
            r_wstate  <= w_wstate_nxt;
            r_aw_full <= w_aw_full_nxt;
            r_w_full  <= w_w_full_nxt;
            r_awaddr  <= w_awaddr_nxt;
            r_wdata   <= w_wdata_nxt;
            r_wstrb   <= w_wstrb_nxt;
            r_bresp   <= w_bresp_nxt;
            r_awready <= w_awready_nxt;
            r_wready  <= w_wready_nxt;
        end
    end

    always_comb begin
        w_rstate_nxt = r_rstate;
        w_rcnt_nxt   = r_rcnt;
        w_rd_err_nxt = r_rd_err;
        w_mem_re     = 1'b0;
        case (r_rstate)
            R_IDLE: begin
                if (arvalid && r_arready) begin
                    w_mem_re     = w_ar_ok;
                    w_rd_err_nxt = !w_ar_ok;
                    if (RD_LATENCY == 1) begin
                        w_rstate_nxt = R_RESP;
                    end else begin
                        w_rstate_nxt = R_WAIT;
                        w_rcnt_nxt   = LAT_LOAD;
                    end
                end
            end
            R_WAIT: begin
                if (r_rcnt == 4'd1) begin
                    w_rstate_nxt = R_RESP;
                end
                w_rcnt_nxt = r_rcnt - 4'd1;
            end
            R_RESP: begin
                if (rready) begin
                    w_rstate_nxt = R_IDLE;
                end
            end
            default: w_rstate_nxt = R_IDLE;
        endcase
    end

    assign w_arready_nxt = (w_rstate_nxt == R_IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rstate  <= R_IDLE;
            r_rcnt    <= 4'd0;
            r_rd_err  <= 1'b0;
            r_arready <= 1'b0;
        end else begin
            r_rstate  <= w_rstate_nxt;
            r_rcnt    <= w_rcnt_nxt;
            r_rd_err  <= w_rd_err_nxt;
            r_arready <= w_arready_nxt;
        end
    end

    axi_sram_array #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .IDX_W       (IDX_W)
    ) u_array (
        .clk     (clk),
        .i_we    (w_mem_we),
        .i_widx  (f_index(r_awaddr)),
        .i_wdata (r_wdata),
        .i_wstrb (r_wstrb),
        .i_re    (w_mem_re),
        .i_ridx  (f_index(araddr)),
        .o_rdata (w_mem_rdata)
    );

    assign awready = r_awready;
    assign wready  = r_wready;
    assign bvalid  = (r_wstate == W_RESP);
    assign bresp   = r_bresp;
    assign arready = r_arready;
    assign rvalid  = (r_rstate == R_RESP);
    assign rresp   = (rvalid && r_rd_err) ? RESP_SLVERR : RESP_OKAY;
    assign rdata   = (rvalid && !r_rd_err) ? w_mem_rdata : '0;

endmodule

// File: tb/tb_axi_lite_sram_slave.sv
// tb/tb_axi_lite_sram_slave.sv - scoreboard bench for axi_lite_sram_slave
module tb_axi_lite_sram_slave;

    localparam int         LAT    = 4;
    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;

    logic        clk, rst;
    logic [31:0] awaddr, wdata, araddr, rdata;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic [3:0]  wstrb;
    logic [1:0]  bresp, rresp;
    logic        arvalid, arready, rvalid, rready;

    int n_cmp = 0;
    int n_bad = 0;

    logic [1:0]  exp_b [$];
    logic [33:0] exp_r [$];
    logic [1:0]  mon_b;
    logic [33:0] mon_r;

    axi_lite_sram_slave #(
        .BASE_ADDR   (32'h0000_0000),
        .DEPTH_WORDS (1024),
        .RD_LATENCY  (LAT)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .awaddr  (awaddr),
        .awvalid (awvalid),
        .awready (awready),
        .wdata   (wdata),
        .wstrb   (wstrb),
        .wvalid  (wvalid),
        .wready  (wready),
        .bresp   (bresp),
        .bvalid  (bvalid),
        .bready  (bready),
        .araddr  (araddr),
        .arvalid (arvalid),
        .arready (arready),
        .rdata   (rdata),
        .rresp   (rresp),
        .rvalid  (rvalid),
        .rready  (rready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: pops the scoreboard whenever a response handshake is about to happen.
    always @(negedge clk) begin
        if (!rst && bvalid && bready) begin
            if (exp_b.size() == 0) begin
                chk("b_unexpected", 32'(bresp), 32'hFFFF_FFFF);
            end else begin
                mon_b = exp_b.pop_front();
                chk("bresp", 32'(bresp), 32'(mon_b));
            end
        end
        if (!rst && rvalid && rready) begin
            if (exp_r.size() == 0) begin
                chk("r_unexpected", rdata, 32'hFFFF_FFFF);
            end else begin
                mon_r = exp_r.pop_front();
                chk("rdata", rdata, mon_r[31:0]);
                chk("rresp", 32'(rresp), 32'(mon_r[33:32]));
            end
        end
    end

    task automatic do_write(input logic [31:0] a, input logic [31:0] d,
                            input logic [3:0] s, input logic [1:0] er);
        int n;
        n = 0;
        while (!(awready && wready) && n < 20) begin
            tick();
            n++;
        end
        chk("wr_ready", 32'(awready && wready), 32'd1);
        exp_b.push_back(er);
        awaddr = a; wdata = d; wstrb = s;
        awvalid = 1'b1; wvalid = 1'b1;
        tick();
        awvalid = 1'b0; wvalid = 1'b0;
        n = 1;
        while (!bvalid && n < 20) begin
            tick();
            n++;
        end
        chk("b_latency", 32'(n), 32'd2);
        tick();
    endtask

    task automatic do_read(input logic [31:0] a, input logic [31:0] ed,
                           input logic [1:0] er, input int hold);
        int  n;
        logic ar_hi;
        n = 0;
        while (!arready && n < 20) begin
            tick();
            n++;
        end
        chk("ar_ready", 32'(arready), 32'd1);
        if (hold > 0) rready = 1'b0;
        exp_r.push_back({er, ed});
        araddr = a; arvalid = 1'b1;
        tick();
        arvalid = 1'b0;
        ar_hi = 1'b0;
        n = 1;
        while (!rvalid && n < 40) begin
            ar_hi = ar_hi | arready;
            tick();
            n++;
        end
        chk("r_latency", 32'(n), 32'(LAT));
        chk("arready_low_wait", 32'(ar_hi), 32'd0);
        for (int i = 0; i < hold; i++) begin
            chk("hold_rvalid", 32'(rvalid), 32'd1);
            chk("hold_rdata", rdata, ed);
            chk("hold_rresp", 32'(rresp), 32'(er));
            chk("hold_arready", 32'(arready), 32'd0);
            tick();
        end
        rready = 1'b1;
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int  n;
        logic b_hi;
        rst = 1'b1;
        awaddr = '0; awvalid = 1'b0; wdata = '0; wstrb = '0; wvalid = 1'b0;
        bready = 1'b0; araddr = '0; arvalid = 1'b0; rready = 1'b0;
        repeat (3) tick();
        chk("rst_awready", 32'(awready), 32'd0);
        chk("rst_wready", 32'(wready), 32'd0);
        chk("rst_arready", 32'(arready), 32'd0);
        chk("rst_bvalid", 32'(bvalid), 32'd0);
        chk("rst_rvalid", 32'(rvalid), 32'd0);
        chk("rst_bresp", 32'(bresp), 32'd0);
        chk("rst_rresp", 32'(rresp), 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        rst = 1'b0;
        tick();
        chk("rel_awready", 32'(awready), 32'd1);
        chk("rel_wready", 32'(wready), 32'd1);
        chk("rel_arready", 32'(arready), 32'd1);
        bready = 1'b1;
        rready = 1'b1;

        // AW and W in the same cycle
        do_write(32'h10, 32'hDEAD_BEEF, 4'hF, OKAY);
        do_read(32'h10, 32'hDEAD_BEEF, OKAY, 0);

        // W three cycles ahead of AW, then a partial-strobe overwrite
        wdata = 32'h1122_3344; wstrb = 4'hF; wvalid = 1'b1;
        tick();
        wvalid = 1'b0;
        tick();
        tick();
        chk("wonly_bvalid", 32'(bvalid), 32'd0);
        chk("wonly_awready", 32'(awready), 32'd1);
        chk("wonly_wready", 32'(wready), 32'd0);
        exp_b.push_back(OKAY);
        awaddr = 32'h20; awvalid = 1'b1;
        tick();
        awvalid = 1'b0;
        n = 1;
        while (!bvalid && n < 20) begin
            tick();
            n++;
        end
        chk("late_aw_b_latency", 32'(n), 32'd2);
        tick();
        do_write(32'h20, 32'hAABB_CCDD, 4'b0101, OKAY);
        do_read(32'h20, 32'h11BB_33DD, OKAY, 0);

        // Range boundary, zero strobe, unaligned address
        do_write(32'h0, 32'hCAFE_F00D, 4'hF, OKAY);
        do_write(32'h1000, 32'h5555_5555, 4'hF, SLVERR);
        do_read(32'h1000, 32'h0, SLVERR, 0);
        do_read(32'h0, 32'hCAFE_F00D, OKAY, 0);
        do_read(32'hFFC, 32'h0, OKAY, 0);
        do_read(32'hFFFF_FFFC, 32'h0, SLVERR, 0);
        do_write(32'h10, 32'h0, 4'h0, OKAY);
        do_read(32'h13, 32'hDEAD_BEEF, OKAY, 0);

        // rready held low: response must stay put
        do_read(32'h20, 32'h11BB_33DD, OKAY, 10);

        // Read sampled on the same edge the write commits returns old data
        do_write(32'h40, 32'h0102_0304, 4'hF, OKAY);
        exp_b.push_back(OKAY);
        exp_r.push_back({OKAY, 32'h0102_0304});
        awaddr = 32'h40; wdata = 32'hA5A5_A5A5; wstrb = 4'hF;
        awvalid = 1'b1; wvalid = 1'b1;
        tick();
        awvalid = 1'b0; wvalid = 1'b0;
        araddr = 32'h40; arvalid = 1'b1;
        tick();
        arvalid = 1'b0;
        repeat (8) tick();
        do_read(32'h40, 32'hA5A5_A5A5, OKAY, 0);

        // Reset one cycle after an AW-only handshake abandons the write
        do_write(32'h30, 32'h7777_8888, 4'hF, OKAY);
        awaddr = 32'h30; awvalid = 1'b1;
        tick();
        awvalid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst_awready", 32'(awready), 32'd0);
        tick();
        chk("postrst_awready", 32'(awready), 32'd1);
        chk("postrst_wready", 32'(wready), 32'd1);
        wdata = 32'h0BAD_F00D; wstrb = 4'hF; wvalid = 1'b1;
        tick();
        wvalid = 1'b0;
        b_hi = 1'b0;
        for (int i = 0; i < 5; i++) begin
            b_hi = b_hi | bvalid;
            tick();
        end
        chk("postrst_no_b", 32'(b_hi), 32'd0);
        exp_b.push_back(OKAY);
        awaddr = 32'h34; awvalid = 1'b1;
        tick();
        awvalid = 1'b0;
        n = 1;
        while (!bvalid && n < 20) begin
            tick();
            n++;
        end
        chk("postrst_b_latency", 32'(n), 32'd2);
        tick();
        do_read(32'h30, 32'h7777_8888, OKAY, 0);
        do_read(32'h34, 32'h0BAD_F00D, OKAY, 0);

        repeat (3) tick();
        chk("b_queue_drained", 32'(exp_b.size()), 32'd0);
        chk("r_queue_drained", 32'(exp_r.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
